// File: rtl/tag_scrub_writer.sv
// tag_scrub_writer: serialises tagged writes, scrubs H->L downgrades and sweeps flushes in constant time
module tag_scrub_writer #(
  parameter int N_ENTRIES = 16,
  parameter int IDX_W     = 4,
  parameter int DATA_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [IDX_W-1:0]     req_idx,
  input  logic                 req_tag,
  input  logic [DATA_W-1:0]    req_data,
  input  logic                 flush_req,
  output logic                 flush_busy,
  output logic                 flush_done,
  output logic                 wr_en,
  output logic [IDX_W-1:0]     wr_idx,
  output logic                 wr_tag,
  output logic [DATA_W-1:0]    wr_data,
  output logic [N_ENTRIES-1:0] tags_o
);
  typedef enum logic [1:0] {IDLE, SCRUB, COMMIT, FLUSH} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_ENTRIES - 1);
  state_t state, state_nx;
  logic [IDX_W-1:0] cnt, lat_idx;
  logic [DATA_W-1:0] lat_data;
  logic [N_ENTRIES-1:0] tags;
  logic accept, down;
  assign req_ready = (state == IDLE) && !flush_req;
  assign accept = req_valid && req_ready;
  assign down = tags[req_idx] && !req_tag;
  assign tags_o = tags;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = flush_req ? FLUSH : (accept && down) ? SCRUB : IDLE;
      SCRUB:   state_nx = COMMIT;
      COMMIT:  state_nx = IDLE;
      FLUSH:   state_nx = (cnt == LAST) ? IDLE : FLUSH;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // Reset forces all-H: array contents survive reset, so no entry may be trusted as L.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_idx     <= '0;
      wr_tag     <= 1'b1;
      wr_data    <= '0;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
      tags       <= '1;
      cnt        <= '0;
      lat_idx    <= '0;
      lat_data   <= '0;
    end else begin
      wr_en      <= 1'b0;
      flush_done <= 1'b0;
      case (state)
        IDLE:
          if (flush_req) begin
            flush_busy <= 1'b1;
            cnt        <= '0;
            wr_en      <= 1'b1;
            wr_idx     <= '0;
            wr_tag     <= 1'b0;
            wr_data    <= '0;
          end else if (accept) begin
            wr_en    <= 1'b1;
            wr_idx   <= req_idx;
            lat_idx  <= req_idx;
            lat_data <= req_data;
            wr_tag   <= down ? 1'b1 : req_tag;
            wr_data  <= down ? '0 : req_data;
            if (!down) tags[req_idx] <= req_tag;
          end
        SCRUB: begin
          wr_en   <= 1'b1;
          wr_idx  <= lat_idx;
          wr_tag  <= 1'b0;
          wr_data <= lat_data;
        end
        COMMIT: tags[lat_idx] <= 1'b0;
        FLUSH: begin
          tags[cnt] <= 1'b0;
          if (cnt == LAST) begin
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end else begin
            cnt    <= cnt + 1'b1;
            wr_en  <= 1'b1;
            wr_idx <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
